// File: rtl/dmem_arbiter.sv
// Two-port (CPU/debug) arbiter and sequencer for a level-sensitive 1000-word data memory.
// Latency: 2 cycles from acceptance in IDLE to the ack pulse; one transaction per 3 cycles.
// Backpressure: requesters hold req and fields stable until ack; a req seen while busy waits for IDLE.
//
// Ports: c_* / d_* request ports (req, we, addr, wdata in; ack, rdata, err out),
//        mem_w/mem_r/mem_in/mem_waddr drive the memory, mem_out returns its read data,
//        busy is high whenever the sequencer is not in IDLE.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin tie-breaking
// (undefined: fixed priority, CPU wins ties).
module dmem_arbiter #(
    parameter int DEPTH = 1000,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [DW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    output logic          c_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_w,
    output logic          mem_r,
    output logic [DW-1:0] mem_in,
    output logic [DW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_out,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

    logic [1:0]    state;
    logic          own_d;      // 1 = debug port owns the current transaction
    logic          lat_we;
    logic          lat_err;

    logic          any_req;
    logic          grant_d;
    logic          win_we;
    logic [DW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_ok;
    logic [DW-1:0] resp_data;

    assign any_req = c_req | d_req;

`ifdef DMEM_ARB_RR_EN
    // Remembers who was granted last; on a tie the other port wins.
    logic last_d;

    assign grant_d = d_req & (~c_req | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b1;
        end else if (state == S_IDLE && any_req) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req & ~c_req;
`endif

    assign win_we    = grant_d ? d_we    : c_we;
    assign win_addr  = grant_d ? d_addr  : c_addr;
    assign win_wdata = grant_d ? d_wdata : c_wdata;
    // Full-width compare: high address bits must not alias into the array.
    assign win_ok    = (win_addr < DEPTH_W);

    // Read data is only returned for in-range loads; stores and errors return 0.
    assign resp_data = (!lat_we && !lat_err) ? mem_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            own_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            busy      <= 1'b0;
            mem_w     <= 1'b0;
            mem_r     <= 1'b0;
            mem_in    <= '0;
            mem_waddr <= '0;
            c_ack     <= 1'b0;
            d_ack     <= 1'b0;
            c_err     <= 1'b0;
            d_err     <= 1'b0;
            c_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state   <= S_ACCESS;
                        busy    <= 1'b1;
                        own_d   <= grant_d;
                        lat_we  <= win_we;
                        lat_err <= ~win_ok;
                        // Strobes and pins are loaded here so they are registered
                        // and valid for exactly the ACCESS cycle.
                        mem_w     <= win_we & win_ok;
                        mem_r     <= ~win_we & win_ok;
                        mem_waddr <= (win_we && win_ok) ? win_addr : '0;
                        mem_in    <= !win_ok ? '0 : (win_we ? win_wdata : win_addr);
                    end
                end
                S_ACCESS: begin
                    state     <= S_RESP;
                    mem_w     <= 1'b0;
                    mem_r     <= 1'b0;
                    mem_in    <= '0;
                    mem_waddr <= '0;
                    c_ack     <= ~own_d;
                    d_ack     <= own_d;
                    c_err     <= ~own_d & lat_err;
                    d_err     <= own_d & lat_err;
                    c_rdata   <= own_d ? '0 : resp_data;
                    d_rdata   <= own_d ? resp_data : '0;
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    c_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    c_err   <= 1'b0;
                    d_err   <= 1'b0;
                    c_rdata <= '0;
                    d_rdata <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_ack, d_ack, c_err, d_err;
    logic [15:0] c_rdata, d_rdata;
    logic        mem_w, mem_r, busy;
    logic [15:0] mem_in, mem_waddr, mem_out;

    int vectors = 0;
    int miscompares = 0;

    // Memory device model: reads mem_in[9:0], writes while mem_w is high.
    logic [15:0] dev_mem [0:1023];
    // Reference view of what the memory should hold, maintained by the bench only.
    logic [15:0] ref_mem [0:1023];

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_w(mem_w), .mem_r(mem_r), .mem_in(mem_in), .mem_waddr(mem_waddr),
        .mem_out(mem_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_w) dev_mem[mem_waddr[9:0]] <= mem_in;
    assign mem_out = dev_mem[mem_in[9:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_exclusive", 128'(mem_w & mem_r), 128'd0);
            chk("ack_exclusive", 128'(c_ack & d_ack), 128'd0);
        end
    end

    // Reference model: {err, rdata} for a transaction, from the address rule alone.
    function automatic logic [16:0] model(input bit we, input logic [15:0] addr);
        logic err;
        logic [15:0] rd;
        err = (int'(addr) >= 1000);
        rd  = (!we && !err) ? ref_mem[addr[9:0]] : 16'h0;
        return {err, rd};
    endfunction

    task automatic wait_ack(output bit gc, output bit gd, output int cyc);
        cyc = 0; gc = 0; gd = 0;
        while (cyc < 20 && !gc && !gd) begin
            @(negedge clk);
            cyc++;
            gc = c_ack;
            gd = d_ack;
        end
        if (!gc && !gd) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no ack after %0d cycles, required within 20", cyc);
        end
    endtask

    // Issues one transaction from an idle arbiter and checks every cycle of it.
    // Entry/exit: 1 time unit after a rising edge, arbiter in IDLE, both reqs low.
    task automatic run_one(input bit port, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit exp_err,
                           input logic [15:0] exp_rdata);
        if (port) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
        end
        @(negedge clk);
        chk("idle_cycle", {mem_w, mem_r, busy}, 3'b000);
        @(negedge clk);
        chk("access_busy_noack", {busy, c_ack, d_ack}, 3'b100);
        if (exp_err)
            chk("access_err_nostrobe", {mem_w, mem_r}, 2'b00);
        else if (we)
            chk("access_store", {mem_w, mem_r, mem_waddr, mem_in}, {2'b10, addr, wdata});
        else
            chk("access_load", {mem_w, mem_r, mem_in}, {2'b01, addr});
        @(negedge clk);
        chk("resp_strobes_busy", {mem_w, mem_r, busy}, 3'b001);
        if (port)
            chk("resp_d", {c_ack, d_ack, c_err, d_err, c_rdata, d_rdata},
                {1'b0, 1'b1, 1'b0, exp_err, 16'h0, exp_rdata});
        else
            chk("resp_c", {c_ack, d_ack, c_err, d_err, c_rdata, d_rdata},
                {1'b1, 1'b0, exp_err, 1'b0, exp_rdata, 16'h0});
        c_req = 1'b0;
        d_req = 1'b0;
        if (we && !exp_err) ref_mem[addr[9:0]] = wdata;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          port;     // 0 = CPU, 1 = debug
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t tbl [12];
        bit   gc, gd;
        int   cyc;
        logic [16:0] m;
        bit   exp_order [3];

        tbl[0]  = '{0, 1, 16'd5,     16'hBEEF, 0, 16'h0000};
        tbl[1]  = '{0, 0, 16'd5,     16'h0000, 0, 16'hBEEF};
        tbl[2]  = '{1, 0, 16'd1000,  16'h0000, 1, 16'h0000};
        tbl[3]  = '{1, 1, 16'd999,   16'h1234, 0, 16'h0000};
        tbl[4]  = '{1, 0, 16'd999,   16'h0000, 0, 16'h1234};
        tbl[5]  = '{0, 1, 16'hFFFF,  16'hA5A5, 1, 16'h0000};
        tbl[6]  = '{0, 0, 16'hFFFF,  16'h0000, 1, 16'h0000};
        tbl[7]  = '{1, 0, 16'd5,     16'h0000, 0, 16'hBEEF};
        tbl[8]  = '{0, 0, 16'd999,   16'h0000, 0, 16'h1234};
        tbl[9]  = '{0, 1, 16'd1029,  16'hDEAD, 1, 16'h0000};
        tbl[10] = '{0, 0, 16'd5,     16'h0000, 0, 16'hBEEF};
        tbl[11] = '{1, 0, 16'd0,     16'h0000, 0, 16'h0001};

`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif

        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        #12;
        chk("reset_outputs", {c_ack, d_ack, c_err, d_err, c_rdata, d_rdata,
                              mem_w, mem_r, mem_in, mem_waddr, busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload through the debug port: addresses 0..15 hold 1..16.
        for (int a = 0; a < 16; a++)
            run_one(1, 1, 16'(a), 16'(a + 1), 0, 16'h0);
        for (int a = 990; a < 1000; a++)
            run_one(1, 1, 16'(a), 16'($urandom), 0, 16'h0);

        for (int i = 0; i < 12; i++)
            run_one(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                    tbl[i].exp_err, tbl[i].exp_rdata);

        // Debug request arriving while the CPU is being served.
        c_we = 0; c_addr = 16'd3; c_req = 1;
        @(posedge clk);
        #1;
        d_we = 0; d_addr = 16'd990; d_req = 1;
        wait_ack(gc, gd, cyc);
        chk("busy_first_c", {gc, gd}, 2'b10);
        chk("busy_c_rdata", c_rdata, 16'd4);
        c_req = 0;
        wait_ack(gc, gd, cyc);
        chk("busy_then_d", {gc, gd}, 2'b01);
        chk("busy_d_gap", 128'(cyc), 128'd3);
        chk("busy_d_rdata", d_rdata, ref_mem[990]);
        d_req = 0;
        @(posedge clk);
        #1;

        // Back-to-back CPU loads with req held high.
        c_we = 0; c_addr = 16'd0; c_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(gc, gd, cyc);
            chk("b2b_gap", 128'(cyc), 128'd3);
            chk("b2b_rdata", {gc, c_rdata}, {1'b1, 16'(k + 1)});
            c_addr = 16'(k + 1);
        end
        c_req = 0;
        @(posedge clk);
        #1;

        // Reset asserted during the ACCESS cycle of a CPU load.
        c_we = 0; c_addr = 16'd2; c_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_access", {mem_r, busy}, 2'b11);
        #1;
        rst_n = 1'b0;
        c_req = 0;
        #1;
        chk("rst_async_outputs", {c_ack, d_ack, c_err, d_err, c_rdata, d_rdata,
                                  mem_w, mem_r, mem_in, mem_waddr, busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_ack", {c_ack, busy}, 2'b00);
        end
        @(posedge clk);
        #1;
        run_one(1, 0, 16'd2, 16'h0, 0, ref_mem[2]);

        // Simultaneous requests three times in a row.
        c_we = 0; c_addr = 16'd1; d_we = 0; d_addr = 16'd2;
        c_req = 1; d_req = 1;
        for (int r = 0; r < 3; r++) begin
            wait_ack(gc, gd, cyc);
            chk("tie_winner", {gc, gd}, exp_order[r] ? 2'b01 : 2'b10);
            chk("tie_latency", 128'(cyc), 128'd3);
            chk("tie_rdata", c_rdata | d_rdata, gc ? ref_mem[1] : ref_mem[2]);
            if (gc) c_req = 0; else d_req = 0;
            @(posedge clk);
            #1;
            if (r < 2) begin
                if (gc) c_req = 1; else d_req = 1;
            end
        end
        c_req = 0;
        wait_ack(gc, gd, cyc);
        chk("tie_tail_d", {gc, gd}, 2'b01);
        chk("tie_tail_rdata", d_rdata, ref_mem[2]);
        d_req = 0;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            bit          p, w;
            logic [15:0] a, wd;
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(0, 15));
                1:       a = 16'($urandom_range(990, 999));
                2:       a = 16'($urandom_range(1000, 1010));
                default: a = 16'($urandom_range(1024, 65535));
            endcase
            p  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            m  = model(w, a);
            run_one(p, w, a, wd, m[16], m[15:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
